// File: rtl/sa_cache.sv
// -----------------------------------------------------------------------------
// sa_cache
//   4-way set-associative, write-back, write-allocate data cache sitting between
//   a CPU request port and a word-wide memory port. 256 sets, 64-byte lines of
//   16 x 32-bit words. On a miss a dirty victim is written back one word per
//   cycle, then the line is refilled one word per accepted memory beat, and the
//   request is replayed as a hit.
//
//   Build option: define SA_CACHE_PLRU_EN to replace the true-LRU replacement
//   (2-bit ages per way) with a 3-bit tree pseudo-LRU per set. Invalid ways are
//   always filled first, lowest index first, in both builds.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   i_tag/i_index/      request address {tag[17:0], index[7:0], offset[5:0]};
//   i_offset            offset[1:0] ignored (word access)
//   dataW, memRW        store data, 1 = store / 0 = load
//   i_memory_line       refill word from memory
//   i_memory_response   refill word valid this cycle (only honoured in REFILL)
//   o_data              registered load result
//   line_data           word moving on the memory side (evict or refill), else 0
//   cache_miss          request not yet serviced; CPU holds request stable
//   o_evict_data/addr   write-back word and its byte address
//   o_evict             write-back beat valid
// -----------------------------------------------------------------------------
module sa_cache #(
  parameter int WAYS  = 4,
  parameter int SETS  = 256,
  parameter int WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] i_tag,
  input  logic [7:0]  i_index,
  input  logic [5:0]  i_offset,
  input  logic [31:0] dataW,
  input  logic        memRW,
  input  logic [31:0] i_memory_line,
  input  logic        i_memory_response,
  output logic [31:0] o_data,
  output logic [31:0] line_data,
  output logic        cache_miss,
  output logic [31:0] o_evict_data,
  output logic [31:0] o_evict_addr,
  output logic        o_evict
);

  localparam int WRD_W = $clog2(WORDS);
  localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, EVICT, REFILL, DONE} state_t;

  // Data-side storage: never reset.
  logic [31:0] data_q [WAYS][SETS][WORDS];
  logic [17:0] tag_q  [WAYS][SETS];

  // Control-side storage: cleared by reset.
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
`ifdef SA_CACHE_PLRU_EN
  logic [2:0]        plru_q [SETS];
`else
  logic [2*WAYS-1:0] age_q  [SETS];
`endif

  state_t           state;
  logic [WRD_W-1:0] beat;
  logic [1:0]       vic_way;
  logic [17:0]      vic_tag;
  // Requests are not sampled on the first cycle after reset, so cache_miss
  // reads 0 throughout reset and rises one cycle after release.
  logic             req_en;

  logic [WRD_W-1:0] wsel;
  logic             hit;
  logic [1:0]       hit_way;
  logic [1:0]       repl_way;
  logic [1:0]       victim;
  logic             unused_bits;

  assign wsel        = i_offset[5:2];
  assign unused_bits = ^i_offset[1:0];

`ifdef SA_CACHE_PLRU_EN
  // Tree bits point toward the victim: b[0] selects pair {0,1} / {2,3},
  // b[1] selects within {0,1}, b[2] within {2,3}.
  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] nb;
    nb = b;
    if (!w[1]) begin
      nb[0] = 1'b1;
      nb[1] = ~w[0];
    end else begin
      nb[0] = 1'b0;
      nb[2] = ~w[0];
    end
    return nb;
  endfunction
`else
  // Age 3 = MRU, age 0 = LRU. Ways younger than the touched way age by one;
  // once every way has been touched the ages form a permutation.
  function automatic logic [2*WAYS-1:0] age_touch(input logic [2*WAYS-1:0] ages,
                                                  input logic [1:0] w);
    logic [2*WAYS-1:0] na;
    logic [1:0]        a;
    a  = ages[{w, 1'b0} +: 2];
    na = ages;
    for (int i = 0; i < WAYS; i++) begin
      if (ages[2*i +: 2] > a) na[2*i +: 2] = ages[2*i +: 2] - 2'd1;
    end
    na[{w, 1'b0} +: 2] = 2'd3;
    return na;
  endfunction
`endif

  // Tag lookup
  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[i_index][w] && (tag_q[w][i_index] == i_tag)) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
    end
  end

  // Replacement candidate among valid ways
  always_comb begin
    repl_way = 2'd0;
`ifdef SA_CACHE_PLRU_EN
    if (plru_q[i_index][0]) repl_way = plru_q[i_index][2] ? 2'd3 : 2'd2;
    else                    repl_way = plru_q[i_index][1] ? 2'd1 : 2'd0;
`else
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (age_q[i_index][2*w +: 2] == 2'd0) repl_way = 2'(w);
    end
`endif
  end

  // Invalid way first, lowest index wins
  always_comb begin
    victim = repl_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[i_index][w]) victim = 2'(w);
    end
  end

  always_comb begin
    case (state)
      IDLE:          cache_miss = req_en & ~hit;
      EVICT, REFILL: cache_miss = 1'b1;
      default:       cache_miss = 1'b0;
    endcase
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      vic_way      <= 2'd0;
      vic_tag      <= 18'd0;
      req_en       <= 1'b0;
      o_data       <= 32'd0;
      line_data    <= 32'd0;
      o_evict_data <= 32'd0;
      o_evict_addr <= 32'd0;
      o_evict      <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
`ifdef SA_CACHE_PLRU_EN
        plru_q[s]  <= 3'd0;
`else
        age_q[s]   <= '0;
`endif
      end
    end else begin
      req_en       <= 1'b1;
      o_evict      <= 1'b0;
      o_evict_data <= 32'd0;
      o_evict_addr <= 32'd0;
      line_data    <= 32'd0;
      case (state)
        IDLE: begin
          if (req_en && hit) begin
            if (memRW) dirty_q[i_index][hit_way] <= 1'b1;
            else       o_data <= data_q[hit_way][i_index][wsel];
`ifdef SA_CACHE_PLRU_EN
            plru_q[i_index] <= plru_touch(plru_q[i_index], hit_way);
`else
            age_q[i_index]  <= age_touch(age_q[i_index], hit_way);
`endif
          end else if (req_en) begin
            vic_way <= victim;
            vic_tag <= tag_q[victim][i_index];
            beat    <= '0;
            if (valid_q[i_index][victim] && dirty_q[i_index][victim]) state <= EVICT;
            else                                                      state <= REFILL;
          end
        end
        EVICT: begin
          o_evict      <= 1'b1;
          o_evict_data <= data_q[vic_way][i_index][beat];
          o_evict_addr <= {vic_tag, i_index, beat, 2'b00};
          line_data    <= data_q[vic_way][i_index][beat];
          beat         <= beat + 1'b1;
          if (beat == LAST_BEAT) state <= REFILL;
        end
        REFILL: begin
          if (i_memory_response) begin
            line_data <= i_memory_line;
            beat      <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              valid_q[i_index][vic_way] <= 1'b1;
              dirty_q[i_index][vic_way] <= 1'b0;
              state                     <= DONE;
            end
          end
        end
        DONE: begin
          if (memRW) dirty_q[i_index][vic_way] <= 1'b1;
          else       o_data <= data_q[vic_way][i_index][wsel];
`ifdef SA_CACHE_PLRU_EN
          plru_q[i_index] <= plru_touch(plru_q[i_index], vic_way);
`else
          age_q[i_index]  <= age_touch(age_q[i_index], vic_way);
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag arrays
  always_ff @(posedge clk) begin
    if (state == IDLE && req_en && hit && memRW)
      data_q[hit_way][i_index][wsel] <= dataW;
    if (state == REFILL && i_memory_response) begin
      data_q[vic_way][i_index][beat] <= i_memory_line;
      if (beat == LAST_BEAT) tag_q[vic_way][i_index] <= i_tag;
    end
    // Replayed store merges into the freshly refilled line
    if (state == DONE && memRW)
      data_q[vic_way][i_index][wsel] <= dataW;
  end

endmodule

// File: tb/tb_sa_cache.sv
module tb_sa_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] i_tag;
  logic [7:0]  i_index;
  logic [5:0]  i_offset;
  logic [31:0] dataW;
  logic        memRW;
  logic [31:0] i_memory_line;
  logic        i_memory_response;
  logic [31:0] o_data;
  logic [31:0] line_data;
  logic        cache_miss;
  logic [31:0] o_evict_data;
  logic [31:0] o_evict_addr;
  logic        o_evict;

  int   checks = 0;
  int   errors = 0;
  logic wb_flag = 1'b0;

  always #5 clk = ~clk;

  sa_cache dut (
    .clk(clk), .rst(rst), .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset),
    .dataW(dataW), .memRW(memRW), .i_memory_line(i_memory_line),
    .i_memory_response(i_memory_response), .o_data(o_data), .line_data(line_data),
    .cache_miss(cache_miss), .o_evict_data(o_evict_data), .o_evict_addr(o_evict_addr),
    .o_evict(o_evict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory contents; tag 0 word 2 reflects the written-back store.
  function automatic logic [31:0] mem_word(input logic [17:0] t, input int k);
    if (t == 18'd0) return (wb_flag && k == 2) ? 32'hDEADBEEF : 32'h100 + 32'(k);
    return {t[7:0], 8'h00, 16'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [17:0] t, input logic [7:0] idx, input logic [5:0] off,
                     input logic rw, input logic [31:0] wd);
    i_tag = t; i_index = idx; i_offset = off; memRW = rw; dataW = wd;
  endtask

  // Called while in REFILL; gap_at inserts one idle memory cycle before that beat.
  task automatic refill(input logic [17:0] t, input int nbeats, input int gap_at);
    for (int k = 0; k < nbeats; k++) begin
      if (k == gap_at) begin
        i_memory_response = 1'b0;
        tick();
        check("gap_line", line_data, 32'd0);
        check("gap_miss", {31'd0, cache_miss}, 32'd1);
      end
      i_memory_response = 1'b1;
      i_memory_line     = mem_word(t, k);
      tick();
      check("refill_line", line_data, mem_word(t, k));
      check("refill_miss", {31'd0, cache_miss}, (k == 15) ? 32'd0 : 32'd1);
      check("refill_noevict", {31'd0, o_evict}, 32'd0);
    end
    i_memory_response = 1'b0;
    i_memory_line     = 32'd0;
  endtask

  // Clean miss from IDLE through the replayed read.
  task automatic miss_fill(input logic [17:0] t, input logic [7:0] idx, input logic [5:0] off);
    req(t, idx, off, 1'b0, 32'd0);
    #1;
    check("fill_miss", {31'd0, cache_miss}, 32'd1);
    tick();
    check("fill_noevict", {31'd0, o_evict}, 32'd0);
    refill(t, 16, -1);
    tick();
    check("fill_rdata", o_data, mem_word(t, int'(off[5:2])));
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [31:0] rd_exp [4];
    logic [5:0]  rd_off [4];
    rd_off = '{6'h04, 6'h08, 6'h0C, 6'h10};
    rd_exp = '{32'h101, 32'h102, 32'h103, 32'h104};

    rst = 1'b1;
    i_memory_response = 1'b0;
    i_memory_line = 32'd0;
    req(18'd0, 8'd0, 6'd0, 1'b0, 32'd0);
    repeat (3) tick();
    check("rst_miss", {31'd0, cache_miss}, 32'd0);
    check("rst_odata", o_data, 32'd0);
    check("rst_line", line_data, 32'd0);
    check("rst_evict", {31'd0, o_evict}, 32'd0);
    check("rst_eaddr", o_evict_addr, 32'd0);
    check("rst_edata", o_evict_data, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_miss", {31'd0, cache_miss}, 32'd0);
    tick();
    check("first_miss", {31'd0, cache_miss}, 32'd1);

    // No memory response: the miss waits
    for (int i = 0; i < 10; i++) begin
      tick();
      check("wait_miss", {31'd0, cache_miss}, 32'd1);
      check("wait_evict", {31'd0, o_evict}, 32'd0);
      check("wait_odata", o_data, 32'd0);
    end

    refill(18'd0, 16, 4);
    tick();
    check("done_rdata", o_data, 32'h100);

    for (int i = 0; i < 4; i++) begin
      req(18'd0, 8'd0, rd_off[i], 1'b0, 32'd0);
      #1;
      check("hit_miss", {31'd0, cache_miss}, 32'd0);
      tick();
      check("hit_rdata", o_data, rd_exp[i]);
    end

    req(18'd0, 8'd0, 6'h08, 1'b1, 32'hDEADBEEF);
    #1;
    check("wr_hit_miss", {31'd0, cache_miss}, 32'd0);
    tick();
    req(18'd0, 8'd0, 6'h08, 1'b0, 32'd0);
    tick();
    check("wr_readback", o_data, 32'hDEADBEEF);
    req(18'd0, 8'd0, 6'h0C, 1'b0, 32'd0);
    tick();
    check("wr_neighbor", o_data, 32'h103);

    for (int t = 1; t <= 3; t++) miss_fill(18'(t), 8'd0, 6'd0);

    // Tag 4 forces out the LRU way, which holds dirty tag 0
    req(18'd4, 8'd0, 6'd0, 1'b0, 32'd0);
    #1;
    check("t4_miss", {31'd0, cache_miss}, 32'd1);
    tick();
    check("t4_evict_start", {31'd0, o_evict}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      i_memory_response = 1'b1;
      i_memory_line = 32'hBAD00000 | 32'(k);
      tick();
      exp_w = (k == 2) ? 32'hDEADBEEF : 32'h100 + 32'(k);
      check("evict_vld", {31'd0, o_evict}, 32'd1);
      check("evict_addr", o_evict_addr, {18'd0, 8'h00, 4'(k), 2'b00});
      check("evict_data", o_evict_data, exp_w);
      check("evict_line", line_data, exp_w);
      check("evict_miss", {31'd0, cache_miss}, 32'd1);
    end
    wb_flag = 1'b1;
    refill(18'd4, 16, -1);
    tick();
    check("t4_rdata", o_data, mem_word(18'd4, 0));
    check("t4_evict_end", {31'd0, o_evict}, 32'd0);

    // Tag 0 returns; victim is clean
    miss_fill(18'd0, 8'd0, 6'h08);

`ifdef SA_CACHE_PLRU_EN
    req(18'd1, 8'd0, 6'd0, 1'b0, 32'd0);
    #1;
    check("t1_plru_hit", {31'd0, cache_miss}, 32'd0);
    tick();
    check("t1_plru_rdata", o_data, mem_word(18'd1, 0));
`else
    miss_fill(18'd1, 8'd0, 6'd0);
`endif

    // Reset during refill beat 5
    req(18'd7, 8'd1, 6'h14, 1'b0, 32'd0);
    #1;
    check("r7_miss", {31'd0, cache_miss}, 32'd1);
    tick();
    refill(18'd7, 5, -1);
    i_memory_response = 1'b1;
    i_memory_line = mem_word(18'd7, 5);
    rst = 1'b1;
    #1;
    check("abort_miss", {31'd0, cache_miss}, 32'd0);
    check("abort_odata", o_data, 32'd0);
    check("abort_line", line_data, 32'd0);
    check("abort_evict", {31'd0, o_evict}, 32'd0);
    check("abort_eaddr", o_evict_addr, 32'd0);
    check("abort_edata", o_evict_data, 32'd0);
    tick();
    rst = 1'b0;
    i_memory_response = 1'b0;
    i_memory_line = 32'd0;
    #1;
    check("rearm_miss", {31'd0, cache_miss}, 32'd0);
    tick();
    check("remiss", {31'd0, cache_miss}, 32'd1);
    check("remiss_evict", {31'd0, o_evict}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
